// File: rtl/multiplier_pkg.sv
// Shared types and widths for the signed shift-add multiplier (control FSM and datapath).
package multiplier_pkg;

    localparam int unsigned MUL_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_LOAD     = 3'b000,
        OP_HOLD     = 3'b001,
        OP_ADD      = 3'b010,
        OP_SUB      = 3'b011,
        OP_CLEAR_XA = 3'b100,
        OP_SHIFT    = 3'b101
    } op_t;

endpackage : multiplier_pkg

// File: rtl/multiplier_datapath_add_sub9.sv
// WIDTH+1-bit ripple adder/subtractor; subtract is b inverted with carry-in set.
module add_sub9 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    logic [WIDTH:0] b_x;

    assign b_x = b ^ {(WIDTH+1){sub}};

    // Bit-serial carry chain; the carry out of the top bit is intentionally dropped.
    always_comb begin
        logic c;
        c   = sub;
        sum = '0;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            sum[i] = a[i] ^ b_x[i] ^ c;
            c      = (a[i] & b_x[i]) | (c & (a[i] ^ b_x[i]));
        end
    end

endmodule : add_sub9

// File: rtl/multiplier_datapath.sv
// X:A:B register datapath of the signed shift-add multiplier, driven one op per clock
// by the control FSM; M = B[0] is returned to that FSM.
module multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_Load_Clear,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Din,
    output logic             Xval,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             M
);

    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;
    logic             sub;
    op_t              op_e;

    assign op_e = op_t'(op);
    assign sub  = (op_e == OP_SUB);

    // Both operands sign-extended to WIDTH+1 so the result can never overflow.
    add_sub9 #(
        .WIDTH (WIDTH)
    ) u_add_sub (
        .a   ({a_q[WIDTH-1], a_q}),
        .b   ({Din[WIDTH-1], Din}),
        .sub (sub),
        .sum (sum)
    );

    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        unique case (op_e)
            OP_LOAD: begin
                x_d = 1'b0;
                a_d = '0;
                b_d = Din;
            end
            OP_ADD, OP_SUB: begin
                x_d = sum[WIDTH];
                a_d = sum[WIDTH-1:0];
            end
            OP_CLEAR_XA: begin
                x_d = 1'b0;
                a_d = '0;
            end
            OP_SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
            end
            default: ;  // OP_HOLD and unused codes keep state
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_Load_Clear) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign Xval = x_q;
    assign Aval = a_q;
    assign Bval = b_q;
    assign M    = b_q[0];

endmodule : multiplier_datapath

// File: tb/tb_multiplier_datapath.sv
// Directed self-checking bench for multiplier_datapath with hand-computed expectations.
module tb_multiplier_datapath;
    import multiplier_pkg::*;

    logic       Clk;
    logic       Reset_Load_Clear;
    logic [2:0] op;
    logic [7:0] Din;
    logic       Xval;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       M;

    int n_cmp = 0;
    int n_err = 0;

    multiplier_datapath #(
        .WIDTH (8)
    ) dut (
        .Clk              (Clk),
        .Reset_Load_Clear (Reset_Load_Clear),
        .op               (op),
        .Din              (Din),
        .Xval             (Xval),
        .Aval             (Aval),
        .Bval             (Bval),
        .M                (M)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_st(input string tag, input logic x, input logic [7:0] a, input logic [7:0] b);
        chk(tag, {15'b0, Xval, Aval, Bval}, {15'b0, x, a, b});
        chk({tag, "_m"}, {31'b0, M}, {31'b0, b[0]});
    endtask

    // Apply one op for one clock and settle away from the edge.
    task automatic step(input logic [2:0] o, input logic [7:0] d);
        op  = o;
        Din = d;
        @(posedge Clk);
        #1;
    endtask

    // Signed multiply sequence as the control FSM issues it: 7x (ADD if M, SHIFT), then (SUB if M, SHIFT).
    task automatic mul_run(input string tag, input logic [7:0] mcand, input logic [7:0] mplier);
        step(3'(OP_LOAD), mplier);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_m%0d", tag, i), {31'b0, M}, {31'b0, mplier[i]});
            if (mplier[i]) step(3'(OP_ADD), mcand);
            step(3'(OP_SHIFT), mcand);
        end
        chk($sformatf("%s_m7", tag), {31'b0, M}, {31'b0, mplier[7]});
        if (mplier[7]) step(3'(OP_SUB), mcand);
        step(3'(OP_SHIFT), mcand);
    endtask

    initial begin
        Reset_Load_Clear = 1'b1;
        op  = 3'(OP_HOLD);
        Din = 8'h00;
        step(3'(OP_HOLD), 8'h00);
        Reset_Load_Clear = 1'b0;
        chk_st("por", 1'b0, 8'h00, 8'h00);

        // 1: reset overrides a pending ADD
        step(3'(OP_LOAD), 8'hAA);
        step(3'(OP_ADD), 8'h80);
        step(3'(OP_ADD), 8'hD5);
        chk_st("preload", 1'b1, 8'h55, 8'hAA);
        Reset_Load_Clear = 1'b1;
        step(3'(OP_ADD), 8'h55);
        Reset_Load_Clear = 1'b0;
        chk_st("rst_over_add", 1'b0, 8'h00, 8'h00);

        // 2: load, add, shift
        step(3'(OP_LOAD), 8'h07);
        chk_st("load", 1'b0, 8'h00, 8'h07);
        step(3'(OP_ADD), 8'h05);
        chk_st("add", 1'b0, 8'h05, 8'h07);
        step(3'(OP_SHIFT), 8'h05);
        chk_st("shift", 1'b0, 8'h02, 8'h83);

        // 3: subtract to negative, then shift in ones
        step(3'(OP_CLEAR_XA), 8'h00);
        chk_st("clr", 1'b0, 8'h00, 8'h83);
        step(3'(OP_SUB), 8'h05);
        chk_st("sub_neg", 1'b1, 8'hFB, 8'h83);
        step(3'(OP_SHIFT), 8'h05);
        chk_st("shift_neg", 1'b1, 8'hFD, 8'hC1);

        // Boundaries: 0 - (-128) = +128, 0x7F + 0x7F
        step(3'(OP_CLEAR_XA), 8'h00);
        step(3'(OP_SUB), 8'h80);
        chk_st("sub_m128", 1'b0, 8'h80, 8'hC1);
        step(3'(OP_CLEAR_XA), 8'h00);
        step(3'(OP_ADD), 8'h7F);
        step(3'(OP_ADD), 8'h7F);
        chk_st("add_7f7f", 1'b0, 8'hFE, 8'hC1);

        // 4, 5: full signed multiplies
        mul_run("m3x7", 8'hFD, 8'h07);
        chk_st("m3x7_res", 1'b1, 8'hFF, 8'hEB);
        mul_run("7xm3", 8'h07, 8'hFD);
        chk_st("7xm3_res", 1'b1, 8'hFF, 8'hEB);

        // 6: HOLD and undefined codes, then CLEAR_XA
        step(3'(OP_LOAD), 8'h34);
        step(3'(OP_ADD), 8'h80);
        step(3'(OP_ADD), 8'h92);
        chk_st("pre_hold", 1'b1, 8'h12, 8'h34);
        step(3'b001, 8'hFF);
        chk_st("hold_001", 1'b1, 8'h12, 8'h34);
        step(3'b110, 8'hFF);
        chk_st("hold_110", 1'b1, 8'h12, 8'h34);
        step(3'b111, 8'hFF);
        chk_st("hold_111", 1'b1, 8'h12, 8'h34);
        step(3'(OP_CLEAR_XA), 8'hFF);
        chk_st("clear_xa", 1'b0, 8'h00, 8'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multiplier_datapath
